sd_dat_tx_seq: RTL and testbench

Sequences one SD-card 4-bit-wide write data block onto DAT[3:0]. The frame is a start bit, BLOCK_LEN_NIB payload nibbles and 16 CRC16 bits per lane, then an end bit.
- Owns four serial CRC16-CCITT lanes (poly 0x1021, init 0), one per DAT line.
- Clears the lanes at frame start, clocks each accepted nibble through them, then shifts the CRCs out.
- Sits between the block-write payload FIFO and the SD pad drivers. Generates the bus-clock enable so the SD clock stalls on payload underflow.

---
 rtl/sd_pkg.sv | 25 ++
 rtl/sd_crc16_lane.sv | 49 ++++
 rtl/sd_dat_tx_seq.sv | 164 ++++++++++++++++
 tb/tb_sd_dat_tx_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared types and constants for the SD DAT-line transmit path.
//   sd_state_e    : block-write sequencer states
//   CRC16_POLY    : CRC16-CCITT generator polynomial (x^16 + x^12 + x^5 + 1)
//   SD_DAT_IDLE   : value driven on DAT[3:0] when no symbol is being sent
//   SD_CRC_BITS   : CRC bits appended per DAT lane
//   SD_CRC_IDX_W  : width of the CRC bit index
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        CRC,
        END
    } sd_state_e;

    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [3:0]  SD_DAT_IDLE  = 4'hF;
    localparam int          SD_CRC_BITS  = 16;
    localparam int          SD_CRC_IDX_W = $clog2(SD_CRC_BITS);

endpackage

// File: rtl/sd_crc16_lane.sv
// -----------------------------------------------------------------------------
// sd_crc16_lane
// Serial CRC16-CCITT accumulator for one DAT line (init 0, MSB-first input).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : fold din into the CRC this cycle
//   din        : serial data bit
//   crc        : current CRC register
// -----------------------------------------------------------------------------
module sd_crc16_lane
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        dx;

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        crc_d = crc_q;
        dx    = din ^ crc_q[15];
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (dx ? CRC16_POLY : 16'h0000);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_dat_tx_seq.sv
// -----------------------------------------------------------------------------
// sd_dat_tx_seq
// Sends one 4-bit-wide SD write data block: start bit, BLOCK_LEN_NIB payload
// nibbles, 16 CRC16 bits per lane (MSB first), end bit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request one block (sampled in IDLE only)
//   abort       : synchronous abort, highest priority
//   data        : payload nibble, data[i] -> DAT[i]
//   data_valid  : payload nibble available
//   data_ready  : nibble accepted this cycle (when data_valid is also high)
//   dat_out     : registered DAT[3:0] value to pads
//   dat_oe      : registered pad output enable
//   bus_tick    : registered; dat_out holds a new symbol for the SD clock
//   busy        : sequencer is not IDLE
//   done        : one-cycle pulse after the end bit
// -----------------------------------------------------------------------------
module sd_dat_tx_seq
    import sd_pkg::*;
#(
    parameter int BLOCK_LEN_NIB = 1024,
    parameter int CNT_W         = $clog2(BLOCK_LEN_NIB + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [3:0] dat_out,
    output logic       dat_oe,
    output logic       bus_tick,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0]        LAST_NIB = CNT_W'(BLOCK_LEN_NIB - 1);
    localparam logic [SD_CRC_IDX_W-1:0] LAST_BIT = SD_CRC_IDX_W'(SD_CRC_BITS - 1);

    sd_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SD_CRC_IDX_W-1:0] k_q, k_d;
    logic [3:0]              dat_out_q, dat_out_d;
    logic                    dat_oe_q, dat_oe_d;
    logic                    bus_tick_q, bus_tick_d;
    logic                    done_q, done_d;

    logic [15:0]             lane_crc [4];
    logic [SD_CRC_IDX_W-1:0] bit_idx;
    logic [3:0]              crc_bits;
    logic                    accept;
    logic                    lane_clr;

    assign data_ready = (state_q == DATA) && (cnt_q <= LAST_NIB);
    assign accept     = data_ready && data_valid && !abort;
    assign lane_clr   = (state_q == IDLE) && start && !abort;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        sd_crc16_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (accept),
            .din   (data[i]),
            .crc   (lane_crc[i])
        );
    end

    // Lanes are frozen during CRC; the transmitted bit is selected by k.
    assign bit_idx = LAST_BIT - k_q;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            crc_bits[i] = lane_crc[i][bit_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        dat_out_d  = dat_out_q;
        dat_oe_d   = dat_oe_q;
        bus_tick_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                dat_out_d = SD_DAT_IDLE;
                dat_oe_d  = 1'b0;
                // Only the end bit leaves IDLE with both tick and oe registered high.
                done_d    = bus_tick_q && dat_oe_q;
                if (start) state_d = START;
            end
            START: begin
                dat_out_d  = 4'h0;
                dat_oe_d   = 1'b1;
                bus_tick_d = 1'b1;
                cnt_d      = '0;
                state_d    = DATA;
            end
            DATA: begin
                // Without a nibble dat_out holds and no tick is issued (clock stall).
                if (accept) begin
                    dat_out_d  = data;
                    bus_tick_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_NIB) begin
                        k_d     = '0;
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                dat_out_d  = crc_bits;
                bus_tick_d = 1'b1;
                k_d        = k_q + SD_CRC_IDX_W'(1);
                if (k_q == LAST_BIT) state_d = END;
            end
            END: begin
                dat_out_d  = SD_DAT_IDLE;
                dat_oe_d   = 1'b1;
                bus_tick_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            dat_out_d  = SD_DAT_IDLE;
            dat_oe_d   = 1'b0;
            bus_tick_d = 1'b0;
        end
    end

    // NOTE: reset is asynchronous so the pads are released the moment rst_n
    // falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            dat_out_q  <= SD_DAT_IDLE;
            dat_oe_q   <= 1'b0;
            bus_tick_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            dat_out_q  <= dat_out_d;
            dat_oe_q   <= dat_oe_d;
            bus_tick_q <= bus_tick_d;
            done_q     <= done_d;
        end
    end

    assign dat_out  = dat_out_q;
    assign dat_oe   = dat_oe_q;
    assign bus_tick = bus_tick_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_sd_dat_tx_seq.sv
// -----------------------------------------------------------------------------
// tb_sd_dat_tx_seq
// Directed bench for sd_dat_tx_seq. Three instances (BLOCK_LEN_NIB = 1, 72,
// 1024) share clk/rst_n; each has its own stimulus and output signals.
// -----------------------------------------------------------------------------
module tb_sd_dat_tx_seq;

    localparam logic [71:0] MSG = "123456789";

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [3];
    logic       abort_v [3];
    logic       valid_v [3];
    logic [3:0] data_v  [3];
    logic       ready_v [3];
    logic [3:0] dout_v  [3];
    logic       oe_v    [3];
    logic       tick_v  [3];
    logic       busy_v  [3];
    logic       done_v  [3];

    int checks = 0;
    int errors = 0;

    // per-frame capture (one entry per cycle, sampled on the falling edge)
    logic       tick_q [$];
    logic [3:0] dout_q [$];
    logic       oe_q   [$];
    logic       busy_q [$];
    logic       done_q [$];

    int          n_tick, first_i, last_i, low_in, hold_bad, done_n, done_i, data_bad, abort_i;
    logic [3:0]  first_sym, end_sym;
    logic [15:0] crc_got [4];
    logic [15:0] model   [4];

    always #5 clk = ~clk;

    sd_dat_tx_seq #(.BLOCK_LEN_NIB(1)) u_dut_len1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .data(data_v[0]), .data_valid(valid_v[0]), .data_ready(ready_v[0]),
        .dat_out(dout_v[0]), .dat_oe(oe_v[0]), .bus_tick(tick_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    sd_dat_tx_seq #(.BLOCK_LEN_NIB(72)) u_dut_len72 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .data(data_v[1]), .data_valid(valid_v[1]), .data_ready(ready_v[1]),
        .dat_out(dout_v[1]), .dat_oe(oe_v[1]), .bus_tick(tick_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    sd_dat_tx_seq u_dut_len1024 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .data(data_v[2]), .data_valid(valid_v[2]), .data_ready(ready_v[2]),
        .dat_out(dout_v[2]), .dat_oe(oe_v[2]), .bus_tick(tick_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload source: d=0 constant A, d=1 "123456789" on lane 0, d=2 a pattern.
    function automatic logic [3:0] nib(input int d, input int n);
        case (d)
            0:       return 4'hA;
            1:       return {3'b000, MSG[71-n]};
            default: return 4'(n * 7 + n / 16);
        endcase
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic dx;
        dx = b ^ c[15];
        return {c[14:0], 1'b0} ^ (dx ? 16'h1021 : 16'h0000);
    endfunction

    // Starts a frame on instance d and records every cycle's outputs.
    task automatic run_frame(input int d, input int len, input int stall_at, input int stall_n,
                             input int abort_at, input int pulse_at);
        int fed, stalled, ntk, budget;
        bit aborted;
        fed = 0; stalled = 0; ntk = 0; aborted = 1'b0; abort_i = -1;
        budget = len + 30 + stall_n;
        tick_q.delete(); dout_q.delete(); oe_q.delete(); busy_q.delete(); done_q.delete();
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < budget; c++) begin
            start_v[d] = (c == pulse_at);
            tick_q.push_back(tick_v[d]);
            dout_q.push_back(dout_v[d]);
            oe_q.push_back(oe_v[d]);
            busy_q.push_back(busy_v[d]);
            done_q.push_back(done_v[d]);
            if (tick_v[d]) ntk++;
            abort_v[d] = 1'b0;
            if (abort_at >= 0 && !aborted && ntk == abort_at) begin
                abort_v[d] = 1'b1;
                aborted    = 1'b1;
                abort_i    = c;
            end
            valid_v[d] = 1'b0;
            if (ready_v[d] && fed < len && !abort_v[d]) begin
                if (fed == stall_at && stalled < stall_n) begin
                    stalled++;
                end else begin
                    valid_v[d] = 1'b1;
                    data_v[d]  = nib(d, fed);
                    for (int i = 0; i < 4; i++) model[i] = crc_step(model[i], data_v[d][i]);
                    fed++;
                end
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
        valid_v[d] = 1'b0;
    endtask

    task automatic analyze(input int d, input int len);
        logic [3:0] syms [$];
        n_tick = 0; first_i = -1; last_i = -1; low_in = 0; hold_bad = 0;
        done_n = 0; done_i = -1; data_bad = 0;
        first_sym = 4'hx; end_sym = 4'hx;
        for (int i = 0; i < 4; i++) crc_got[i] = 16'h0000;
        for (int c = 0; c < tick_q.size(); c++) begin
            if (tick_q[c]) begin
                n_tick++;
                if (first_i < 0) first_i = c;
                last_i = c;
                syms.push_back(dout_q[c]);
            end
            if (done_q[c]) begin
                done_n++;
                done_i = c;
            end
        end
        if (first_i >= 0) begin
            for (int c = first_i + 1; c < last_i; c++) begin
                if (!tick_q[c]) begin
                    low_in++;
                    if (dout_q[c] !== dout_q[c-1]) hold_bad++;
                end
            end
        end
        if (syms.size() >= len + 18) begin
            first_sym = syms[0];
            for (int n = 0; n < len; n++) if (syms[1+n] !== nib(d, n)) data_bad++;
            for (int j = 0; j < 16; j++)
                for (int i = 0; i < 4; i++) crc_got[i] = {crc_got[i][14:0], syms[1+len+j][i]};
            end_sym = syms[len+17];
        end else begin
            data_bad = len;
        end
    endtask

    task automatic check_frame(input int len, input int stall_n, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        check("tick_count",  n_tick,   len + 18);
        check("first_tick",  first_i,  1);
        check("start_bit",   first_sym, 4'h0);
        check("stall_cycles", low_in,  stall_n);
        check("stall_hold",  hold_bad, 0);
        check("payload",     data_bad, 0);
        check("crc_lane0",   crc_got[0], e0);
        check("crc_lane1",   crc_got[1], e1);
        check("crc_lane2",   crc_got[2], e2);
        check("crc_lane3",   crc_got[3], e3);
        check("end_bit",     end_sym,  4'hF);
        check("done_count",  done_n,   1);
        check("done_timing", done_i,   last_i + 1);
        check("oe_at_done",  oe_q[done_i], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; abort_v[d] = 1'b0; valid_v[d] = 1'b0; data_v[d] = 4'h0;
        end
        #12;
        // reset values
        check("rst_dat_out", dout_v[0], 4'hF);
        check("rst_dat_oe",  oe_v[0],   1'b0);
        check("rst_tick",    tick_v[0], 1'b0);
        check("rst_ready",   ready_v[0], 1'b0);
        check("rst_busy",    busy_v[0], 1'b0);
        check("rst_done",    done_v[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single nibble A, with a start pulse while busy that must be ignored
        run_frame(0, 1, -1, 0, -1, 5);
        analyze(0, 1);
        check_frame(1, 0, 16'h0000, 16'h1021, 16'h0000, 16'h1021);

        // "123456789" on lane 0 -> XMODEM CRC 0x31C3
        run_frame(1, 72, -1, 0, -1, -1);
        analyze(1, 72);
        check_frame(72, 0, 16'h31C3, 16'h0000, 16'h0000, 16'h0000);

        // abort with CRC bit index 7 pending (1 + 72 + 7 ticks already out)
        run_frame(1, 72, -1, 0, 80, -1);
        analyze(1, 72);
        check("abort_seen",    abort_i >= 0, 1'b1);
        check("abort_tick",    tick_q[abort_i+1], 1'b0);
        check("abort_oe",      oe_q[abort_i+1],   1'b0);
        check("abort_dat_out", dout_q[abort_i+1], 4'hF);
        check("abort_busy",    busy_q[abort_i+1], 1'b0);
        check("abort_no_done", done_n, 0);
        run_frame(1, 72, -1, 0, -1, -1);
        analyze(1, 72);
        check_frame(72, 0, 16'h31C3, 16'h0000, 16'h0000, 16'h0000);

        // start together with abort in IDLE is dropped
        @(negedge clk);
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        check("sa_busy", busy_v[0], 1'b0);
        check("sa_oe",   oe_v[0],   1'b0);
        @(negedge clk);
        check("sa_busy2", busy_v[0], 1'b0);
        check("sa_tick2", tick_v[0], 1'b0);

        // asynchronous reset in the middle of DATA
        @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            valid_v[2] = 1'b1; data_v[2] = 4'h5;
            @(negedge clk);
        end
        check("pre_rst_oe", oe_v[2], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_oe",      oe_v[2],   1'b0);
        check("mid_rst_dat_out", dout_v[2], 4'hF);
        check("mid_rst_busy",    busy_v[2], 1'b0);
        check("mid_rst_tick",    tick_v[2], 1'b0);
        @(negedge clk);
        valid_v[2] = 1'b0;
        rst_n = 1'b1;

        // full block with a 5-cycle underflow before nibble 300
        run_frame(2, 1024, 300, 5, -1, -1);
        analyze(2, 1024);
        check_frame(1024, 5, model[0], model[1], model[2], model[3]);
        check("stall_dat_out", dout_q[first_i+301], nib(2, 299));
        check("stall_tick",    tick_q[first_i+305], 1'b0);
        check("stall_resume",  tick_q[first_i+306], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
